// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Read-side consumer for the dual-clock FIFO. Pops words from the FIFO read
// port and presents them as a valid/ready stream through a 2-entry skid
// buffer. The stream carries burst framing: m_last marks every BURST_LEN-th
// accepted beat.
//
// Optional feature (macro FIFO_RD_STREAM_STATS_EN):
//   adds parameter CNT_W and the saturating statistics outputs rd_count and
//   stall_count. With the macro undefined neither the ports nor the counters
//   exist.
//
// Ports:
//   rclk        in   read-domain clock
//   rrst        in   asynchronous active-high reset
//   en          in   read enable; low stops new pops
//   flush       in   single-cycle pulse; drops buffered words, restarts framing
//   rempty      in   FIFO empty flag (rclk domain)
//   rdata       in   FIFO head word, valid while rempty=0
//   rinc        out  FIFO pop strobe (combinational)
//   m_data      out  stream data (skid entry 0)
//   m_valid     out  stream valid
//   m_ready     in   stream ready
//   m_last      out  final beat of a burst
//   busy        out  skid buffer holds data
//   rd_count    out  pops issued, saturating          (stats build only)
//   stall_count out  cycles with m_valid & ~m_ready   (stats build only)
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned BURST_LEN = 16
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   parameter int unsigned CNT_W     = 16
`endif
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             en,
   input  logic             flush,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             busy
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] stall_count
`endif
);

   // Beat counter needs at least one bit, even for BURST_LEN=1.
   localparam int unsigned         BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0]   BEAT_MAX = BEAT_W'(BURST_LEN - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   localparam logic [1:0] OCC_FULL  = 2'd2;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [1:0]        r_occ;
   logic [DSIZE-1:0]  r_ent0;
   logic [DSIZE-1:0]  r_ent1;
   logic [BEAT_W-1:0] r_beat;

   // -------------------------------------------------------------------------
   // Combinational signals
   // -------------------------------------------------------------------------
   logic              w_valid;
   logic              w_push;
   logic              w_pop;
   logic [1:0]        w_state_nxt;
   logic [1:0]        w_occ_nxt;
   logic [DSIZE-1:0]  w_ent0_nxt;
   logic [DSIZE-1:0]  w_ent1_nxt;
   logic [BEAT_W-1:0] w_beat_nxt;

   assign w_valid = (r_occ != 2'd0);

   // Pop only with room in the skid buffer; flush and reset suppress the pop
   // so the FIFO never gives up a word that would be thrown away.
   assign w_push  = en & ~rempty & ~flush & ~rrst & (r_occ != OCC_FULL);

   assign w_pop   = w_valid & m_ready;

   // -------------------------------------------------------------------------
   // Skid buffer and beat counter next-state
   // -------------------------------------------------------------------------
   always_comb begin
      w_occ_nxt  = r_occ;
      w_ent0_nxt = r_ent0;
      w_ent1_nxt = r_ent1;
      w_beat_nxt = r_beat;

      if (flush) begin
         // An accept in this cycle is ignored internally.
         w_occ_nxt  = 2'd0;
         w_beat_nxt = '0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) begin
                  w_ent0_nxt = rdata;
               end else begin
                  w_ent1_nxt = rdata;
               end
               w_occ_nxt = r_occ + 2'd1;
            end
            2'b01: begin
               // Shift entry 1 forward; stale when occ was 1, harmless.
               w_ent0_nxt = r_ent1;
               w_occ_nxt  = r_occ - 2'd1;
            end
            2'b11: begin
               // Push needs occ<2 and pop needs occ>0, so occ is 1 here:
               // the departing head is replaced directly by the new word.
               w_ent0_nxt = rdata;
            end
            default: begin
            end
         endcase

         if (w_pop) begin
            w_beat_nxt = (r_beat == BEAT_MAX) ? '0 : r_beat + BEAT_W'(1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM next-state
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;

      unique case (r_state)
         ST_IDLE: begin
            if (w_push) begin
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (flush || (w_occ_nxt == 2'd0)) begin
               w_state_nxt = ST_IDLE;
            end else if (!en) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (flush || (w_occ_nxt == 2'd0)) begin
               w_state_nxt = ST_IDLE;
            end else if (en) begin
               w_state_nxt = ST_STREAM;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_state <= ST_IDLE;
         r_occ   <= 2'd0;
         r_ent0  <= '0;
         r_ent1  <= '0;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_occ   <= w_occ_nxt;
         r_ent0  <= w_ent0_nxt;
         r_ent1  <= w_ent1_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: all are direct decodes of registered state except rinc
   // -------------------------------------------------------------------------
   assign rinc    = w_push;
   assign m_data  = r_ent0;
   assign m_valid = w_valid;
   assign m_last  = w_valid & (r_beat == BEAT_MAX);
   assign busy    = w_valid;

`ifdef FIFO_RD_STREAM_STATS_EN
   // -------------------------------------------------------------------------
   // Saturating statistics; only reset clears them, flush does not
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] r_rd_count;
   logic [CNT_W-1:0] r_stall_count;

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_rd_count    <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_push && (r_rd_count != '1)) begin
            r_rd_count <= r_rd_count + CNT_W'(1);
         end
         if (w_valid && !m_ready && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
         end
      end
   end

   assign rd_count    = r_rd_count;
   assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
// Drives fifo_rd_stream from a queue-based FIFO model and checks every cycle
// against a transaction-level reference: a queue of popped-but-undelivered
// words plus an accepted-beat count. A second instance with BURST_LEN=1
// shares the stimulus. Stats outputs are checked when the macro
// FIFO_RD_STREAM_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

   localparam int unsigned DW = 8;
   localparam int unsigned BL = 16;

   logic          rclk = 1'b0;
   logic          rrst;
   logic          en;
   logic          flush;
   logic          rempty;
   logic [DW-1:0] rdata;
   logic          m_ready;

   logic          rinc0,   rinc1;
   logic [DW-1:0] m_data0, m_data1;
   logic          m_valid0, m_valid1;
   logic          m_last0, m_last1;
   logic          busy0,   busy1;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [15:0]   rd_count0, stall_count0, rd_count1, stall_count1;
`endif

   always #5 rclk = ~rclk;

   fifo_rd_stream #(.DSIZE(DW), .BURST_LEN(BL)) u_dut (
      .rclk(rclk), .rrst(rrst), .en(en), .flush(flush), .rempty(rempty),
      .rdata(rdata), .rinc(rinc0), .m_data(m_data0), .m_valid(m_valid0),
      .m_ready(m_ready), .m_last(m_last0),
`ifdef FIFO_RD_STREAM_STATS_EN
      .rd_count(rd_count0), .stall_count(stall_count0),
`endif
      .busy(busy0)
   );

   fifo_rd_stream #(.DSIZE(DW), .BURST_LEN(1)) u_dut1 (
      .rclk(rclk), .rrst(rrst), .en(en), .flush(flush), .rempty(rempty),
      .rdata(rdata), .rinc(rinc1), .m_data(m_data1), .m_valid(m_valid1),
      .m_ready(m_ready), .m_last(m_last1),
`ifdef FIFO_RD_STREAM_STATS_EN
      .rd_count(rd_count1), .stall_count(stall_count1),
`endif
      .busy(busy1)
   );

   // Reference model state
   logic [DW-1:0] src[$];     // FIFO contents
   logic [DW-1:0] sb_q[$];    // words popped, not yet accepted
   int            beat;       // accepted beats modulo BL
   int unsigned   mdl_rd;
   int unsigned   mdl_stall;
   logic [DW-1:0] next_word;
   int            n_pass;
   int            n_chk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         src.push_back(next_word);
         next_word = next_word + 8'd1;
      end
   endtask

   // One clock cycle: drive at negedge, check 1ns later, advance the model
   // to what the next posedge commits.
   task automatic cyc(input logic i_en, input logic i_fl, input logic i_rdy, input logic i_gate);
      logic e_valid, e_rinc, e_last;
      @(negedge rclk);
      en      = i_en;
      flush   = i_fl;
      m_ready = i_rdy;
      rempty  = (src.size() == 0) || i_gate;
      rdata   = (src.size() != 0) ? src[0] : DW'($urandom);
      #1;
      e_valid = (sb_q.size() != 0);
      e_rinc  = i_en && !rempty && !i_fl && (sb_q.size() < 2);
      e_last  = e_valid && (beat == BL - 1);

      chk("rinc",     32'(rinc0),    32'(e_rinc));
      chk("m_valid",  32'(m_valid0), 32'(e_valid));
      chk("busy",     32'(busy0),    32'(e_valid));
      chk("m_last",   32'(m_last0),  32'(e_last));
      chk("rinc_bl1", 32'(rinc1),    32'(e_rinc));
      chk("last_bl1", 32'(m_last1),  32'(e_valid));
      if (e_valid) begin
         chk("m_data",     32'(m_data0), 32'(sb_q[0]));
         chk("m_data_bl1", 32'(m_data1), 32'(sb_q[0]));
      end
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("rd_count",    32'(rd_count0),    mdl_rd);
      chk("stall_count", 32'(stall_count0), mdl_stall);
`endif

      if (e_rinc && (mdl_rd < 32'hFFFF)) mdl_rd++;
      if (e_valid && !i_rdy && (mdl_stall < 32'hFFFF)) mdl_stall++;
      if (i_fl) begin
         sb_q.delete();
         beat = 0;
      end else if (e_valid && i_rdy) begin
         void'(sb_q.pop_front());
         beat = (beat + 1) % BL;
      end
      if (e_rinc) sb_q.push_back(src.pop_front());
   endtask

   initial begin
      n_pass = 0; n_chk = 0; beat = 0; mdl_rd = 0; mdl_stall = 0;
      next_word = 8'h01;

      // Reset state; en high and rempty low show rinc is gated in reset
      rrst = 1'b1; en = 1'b1; flush = 1'b0; rempty = 1'b0; rdata = 8'hA5; m_ready = 1'b0;
      #2;
      chk("rst_rinc",    32'(rinc0),    32'd0);
      chk("rst_m_valid", 32'(m_valid0), 32'd0);
      chk("rst_m_data",  32'(m_data0),  32'd0);
      chk("rst_m_last",  32'(m_last0),  32'd0);
      chk("rst_busy",    32'(busy0),    32'd0);
      @(negedge rclk);
      en = 1'b0; rempty = 1'b1;
      rrst = 1'b0;

      // Preloaded 0x01..0x20 streamed at full rate
      load(32);
      for (int k = 0; k < 36; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);

      // Backpressure: 5 stall cycles with 4 words available
      load(4);
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);

      // rempty toggling every cycle, random ready
      load(10);
      for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'(k % 2));

      // en drop mid-burst with a full buffer, then resume
      load(40);
      for (int k = 0; k < 40 && beat != 5; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);

      // flush with a full buffer at beat 9, then a fresh burst
      load(60);
      for (int k = 0; k < 40 && beat != 9; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 24; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);

      // Random soak
      for (int k = 0; k < 400; k++) begin
         if (src.size() < 4) load(8);
         cyc(1'(($urandom % 8) != 0), 1'(($urandom % 32) == 0),
             1'(($urandom % 4) != 0), 1'(($urandom % 3) == 0));
      end

      // Asynchronous reset while the buffer holds data
      load(4);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge rclk);
      #3;
      rrst = 1'b1;
      #1;
      chk("arst_m_valid", 32'(m_valid0), 32'd0);
      chk("arst_busy",    32'(busy0),    32'd0);
      chk("arst_m_last",  32'(m_last0),  32'd0);
      chk("arst_m_data",  32'(m_data0),  32'd0);
      chk("arst_rinc",    32'(rinc0),    32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("arst_rd_count",    32'(rd_count0),    32'd0);
      chk("arst_stall_count", 32'(stall_count0), 32'd0);
`endif
      sb_q.delete(); beat = 0; mdl_rd = 0; mdl_stall = 0;
      @(negedge rclk);
      en = 1'b0;
      @(negedge rclk);
      rrst = 1'b0;

      // Restart after reset
      load(20);
      for (int k = 0; k < 24; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's dual-clock FIFO. Sits entirely in the rclk domain.
- Pops words using rinc, rempty and rdata, then presents them as a valid/ready stream through a 2-entry skid buffer.
- Adds burst framing by asserting m_last every BURST_LEN beats.
- Gives downstream logic full-throughput, backpressure-safe access to FIFO contents.

Parameters:
- DSIZE, 8, data width; matches FIFO rdata width.
- BURST_LEN, 16, beats per burst; legal range 1..2^16.
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- rclk  in  1  read-domain clock.
- rrst  in  1  asynchronous, active-high reset.
- en  in  1  read enable; when low, no new pops are issued.
- flush  in  1  single-cycle pulse; discards buffered words and restarts burst framing.
- rempty  in  1  FIFO empty flag, synchronous to rclk.
- rdata  in  DSIZE  FIFO head word; valid whenever rempty=0.
- rinc  out  1  FIFO pop strobe.
- m_data  out  DSIZE  output stream data.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_last  out  1  marks the final beat of a burst.
- busy  out  1  high when the skid buffer holds data.

Behaviour:
- Interface decision: one clock (rclk); reset rrst is asynchronous and active-high.
- Reset values: rinc=0, m_valid=0, m_last=0, busy=0, m_data=0. Occupancy and beat counter are 0.
- Skid buffer: 2 entries, FIFO order. occ ranges 0..2. Entry 0 drives m_data.
- Pop rule (combinational): rinc = en & ~rempty & ~flush & (occ<2).
  - rdata is captured into the buffer on the same rclk edge where rinc=1.
- Accept rule: a beat transfers when m_valid & m_ready. m_valid = (occ!=0).
- Occupancy update: push and pop in the same cycle leave occ unchanged.
  - Sustained 1 beat/cycle is reached when FIFO is nonempty and m_ready=1.
- Latency: first rinc to first m_valid is 1 cycle.
- Stall: with occ=2 and m_ready=0, rinc=0 and both entries hold. m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Burst framing:
  - beat counter counts accepted beats, 0..BURST_LEN-1.
  - m_last = m_valid & (beat==BURST_LEN-1).
  - The counter wraps to 0 on the accepted last beat.
  - BURST_LEN=1 gives m_last=1 on every beat.
- State machine:
  - IDLE (occ=0, en=0 or rempty=1).
  - STREAM (popping or holding data).
  - DRAIN (en=0, occ>0: no pops, buffer empties downstream).
  - Transitions: IDLE->STREAM on rinc. STREAM->DRAIN on en fall with occ>0. DRAIN->IDLE when occ reaches 0. DRAIN->STREAM if en returns.
- en deassert mid-burst: pops stop; already-buffered words are still delivered; the beat counter is preserved.
- flush:
  - Next edge: occ=0, beat=0, state=IDLE.
  - rinc is forced 0 in the flush cycle, so no FIFO word is lost.
  - Any accept in the flush cycle is still counted externally but has no internal effect.
- rempty=1: rinc=0; buffer drains normally. rinc is never issued while rempty=1.
- Reset mid-operation: all buffered data is discarded immediately (asynchronous). The FIFO pointer is the FIFO's own responsibility.
- busy = (occ!=0).

Optional Feature:
- Macro: FIFO_RD_STREAM_STATS_EN.
- When defined, add two outputs:
  - rd_count [CNT_W-1:0]: increments on each rinc.
  - stall_count [CNT_W-1:0]: increments each cycle m_valid & ~m_ready.
  - Both saturate at all-ones and are cleared by rrst only, not by flush.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- FIFO preloaded 0x01..0x20, en=1, m_ready=1, BURST_LEN=16 -> rinc high for 32 consecutive cycles; m_data 0x01..0x20 one per cycle; m_last on 0x10 and 0x20.
- 4 words loaded, m_ready=0 for 5 cycles, then 1 -> exactly 2 rinc pulses during stall; m_data holds 0x01; all 4 words then delivered in order.
- rempty toggling every cycle -> rinc never asserted while rempty=1; no duplicated or dropped words.
- en drops after beat 5 with occ=2 -> rinc=0; 2 more beats delivered; state DRAIN then IDLE; beat counter resumes at 7 when en returns.
- flush with occ=2, beat=9 -> next cycle m_valid=0, busy=0; next burst's m_last lands on its 16th beat.
- rrst pulsed while m_valid=1 -> outputs zero asynchronously. With FIFO_RD_STREAM_STATS_EN and 20 pops, rd_count=20 before reset and 0 after.
